// File: rtl/oa_ctrl_loader.sv
// oa_ctrl_loader: stages a 16-bit analog control word and runs the POR/settle/enable power-up sequence
module oa_ctrl_loader #(
  parameter int POR_CYCLES = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_sel,
  input  logic [7:0]  in_data,
  output logic        oa_ena,
  output logic [1:0]  oa_por,
  output logic [15:0] oa_ctrl,
  output logic [3:0]  status_o
);
  typedef enum logic [1:0] {OFF = 2'b00, POR = 2'b01, SETTLE = 2'b10, ON = 2'b11} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0] shadow, shadow_n, active, active_n;
  logic acc, cmd, pon, poff, last;
  assign in_ready = ena & ~rst & (state == OFF | state == ON);
  assign acc = in_valid & in_ready;
  assign cmd = acc & (in_sel == 2'b10);
  assign pon = cmd & in_data[0] & ~in_data[1];
  assign poff = cmd & in_data[1];
  assign last = cnt == '0;
  assign status_o = {state, shadow != active, oa_ena};
  always_comb begin
    shadow_n = acc & (in_sel == 2'b00) ? {shadow[15:8], in_data} :
               acc & (in_sel == 2'b01) ? {in_data, shadow[7:0]} : shadow;
    active_n = cmd & in_data[2] ? shadow : active;
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (!ena) begin
      state_n = OFF;
    end else if (state == OFF && pon) begin
      state_n = POR;
      cnt_n = CNT_W'(POR_CYCLES - 1);
    end else if (state == POR) begin
      state_n = last ? SETTLE : POR;
      cnt_n = last ? CNT_W'(SETTLE_CYCLES - 1) : cnt - 1'b1;
    end else if (state == SETTLE) begin
      state_n = last ? ON : SETTLE;
      cnt_n = last ? cnt : cnt - 1'b1;
    end else if (state == ON && poff) begin
      state_n = OFF;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      cnt <= '0;
      shadow <= '0;
      active <= '0;
      oa_ena <= 1'b0;
      oa_por <= 2'b11;
      oa_ctrl <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shadow <= shadow_n;
      active <= active_n;
      oa_ena <= state_n == ON;
      oa_por <= state_n == ON ? 2'b00 : state_n == SETTLE ? 2'b01 : 2'b11;
      oa_ctrl <= state_n == ON ? active_n : '0;
    end
  end
endmodule

// File: tb/tb_oa_ctrl_loader.sv
// tb_oa_ctrl_loader: directed and randomized checks of oa_ctrl_loader against a timeline-based reference model
module tb_oa_ctrl_loader;
  localparam int PC = 16;
  localparam int SC = 8;
  logic clk = 1'b0;
  logic rst = 1'b1, ena = 1'b0, in_valid = 1'b0;
  logic [1:0] in_sel = 2'b00;
  logic [7:0] in_data = 8'h00;
  logic in_ready, oa_ena;
  logic [1:0] oa_por;
  logic [15:0] oa_ctrl;
  logic [3:0] status_o;
  int tests = 0;
  int fails = 0;
  int m_mode = 0;
  int m_t = 0;
  logic [15:0] m_sh = '0, m_act = '0;
  always #5 clk = ~clk;
  oa_ctrl_loader #(.POR_CYCLES(PC), .SETTLE_CYCLES(SC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .oa_ena(oa_ena), .oa_por(oa_por),
    .oa_ctrl(oa_ctrl), .status_o(status_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic e, input logic v, input logic [1:0] s, input logic [7:0] d);
    logic rdy, acc;
    logic [15:0] sh0;
    logic [1:0] code;
    rst = r;
    ena = e;
    in_valid = v;
    in_sel = s;
    in_data = d;
    #1;
    rdy = e & ~r & (m_mode != 1);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    @(posedge clk);
    acc = v & rdy;
    if (r) begin
      m_mode = 0;
      m_t = 0;
      m_sh = '0;
      m_act = '0;
    end else begin
      sh0 = m_sh;
      if (acc && s == 2'd0) m_sh[7:0] = d;
      if (acc && s == 2'd1) m_sh[15:8] = d;
      if (acc && s == 2'd2 && d[2]) m_act = sh0;
      if (!e) m_mode = 0;
      else if (m_mode == 0 && acc && s == 2'd2 && d[0] && !d[1]) begin
        m_mode = 1;
        m_t = 0;
      end else if (m_mode == 1) begin
        m_t++;
        if (m_t == PC + SC) m_mode = 2;
      end else if (m_mode == 2 && acc && s == 2'd2 && d[1]) m_mode = 0;
    end
    #1;
    code = m_mode == 2 ? 2'd3 : m_mode == 1 ? (m_t < PC ? 2'd1 : 2'd2) : 2'd0;
    chk("oa_ena", 32'(oa_ena), 32'(m_mode == 2));
    chk("oa_por", 32'(oa_por), m_mode == 2 ? 32'd0 : code == 2'd2 ? 32'd1 : 32'd3);
    chk("oa_ctrl", 32'(oa_ctrl), m_mode == 2 ? 32'(m_act) : 32'd0);
    chk("status", 32'(status_o), 32'({code, m_sh != m_act, m_mode == 2}));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
  endtask
  task automatic wr(input logic [1:0] s, input logic [7:0] d);
    cyc(1'b0, 1'b1, 1'b1, s, d);
  endtask
  initial begin
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    idle(1);
    chk("reset_status", 32'(status_o), 32'h0);
    chk("reset_ready", 32'(in_ready), 32'd1);
    wr(2'd0, 8'h5A);
    wr(2'd1, 8'hA5);
    wr(2'd2, 8'h05);
    chk("por_ready", 32'(in_ready), 32'd0);
    idle(23);
    chk("pre_on_ena", 32'(oa_ena), 32'd0);
    chk("pre_on_por", 32'(oa_por), 32'd1);
    idle(1);
    chk("on_ena", 32'(oa_ena), 32'd1);
    chk("on_ctrl", 32'(oa_ctrl), 32'hA55A);
    wr(2'd0, 8'h00);
    chk("staged_ctrl", 32'(oa_ctrl), 32'hA55A);
    chk("staged_pending", 32'(status_o[1]), 32'd1);
    wr(2'd2, 8'h04);
    chk("commit_ctrl", 32'(oa_ctrl), 32'hA500);
    chk("commit_pending", 32'(status_o[1]), 32'd0);
    wr(2'd2, 8'h03);
    chk("off_por", 32'(oa_por), 32'd3);
    chk("off_ctrl", 32'(oa_ctrl), 32'h0);
    wr(2'd2, 8'h01);
    idle(24);
    chk("repower_ctrl", 32'(oa_ctrl), 32'hA500);
    wr(2'd2, 8'h03);
    wr(2'd2, 8'h01);
    idle(18);
    chk("settle_por", 32'(oa_por), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("ena_drop_state", 32'(status_o[3:2]), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 2'd2, 8'h01);
    wr(2'd2, 8'h01);
    idle(24);
    chk("restart_ena", 32'(oa_ena), 32'd1);
    wr(2'd2, 8'h03);
    wr(2'd2, 8'h01);
    idle(3);
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    chk("rst_por", 32'(oa_por), 32'd3);
    chk("rst_state", 32'(status_o), 32'h0);
    idle(1);
    wr(2'd2, 8'h01);
    idle(24);
    chk("rst_cleared_ena", 32'(oa_ena), 32'd1);
    chk("rst_cleared_ctrl", 32'(oa_ctrl), 32'h0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 39) != 0, 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 8'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
